// File: rtl/kernel_top_stream_join2_pkg.sv
// Shared defaults for the two-stream join: word width, FIFO depth, pointer width.
// Also provides a constant-foldable clog2 so parameter defaults can be derived.
// No logic here; imported by the interface, FIFO and top.
package kernel_top_stream_join2_pkg;

  localparam int DEF_STREAMW = 34;
  localparam int DEF_DEPTH   = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_AW = clog2(DEF_DEPTH);

  typedef logic [DEF_STREAMW-1:0] word_t;

endpackage

// File: rtl/kernel_top_stream_join2_if.sv
// Handshake bundle for the join: two input streams, one paired output, skew flag.
// Pure wiring, no latency.
// master drives valids/data/oready; slave (the join) drives readies/output/flag.
interface kernel_top_stream_join2_if
  import kernel_top_stream_join2_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW
);

  logic               ivalid_in1_s0;
  logic [STREAMW-1:0] in1_s0;
  logic               iready_in1_s0;
  logic               ivalid_in2_s0;
  logic [STREAMW-1:0] in2_s0;
  logic               iready_in2_s0;
  logic               ovalid_out1_s0;
  logic               oready_out1_s0;
  logic [STREAMW-1:0] out1_s0;
  logic [STREAMW-1:0] out2_s0;
  logic               skew_err;

  modport master (
    output ivalid_in1_s0, in1_s0, ivalid_in2_s0, in2_s0, oready_out1_s0,
    input  iready_in1_s0, iready_in2_s0, ovalid_out1_s0, out1_s0, out2_s0, skew_err
  );

  modport slave (
    input  ivalid_in1_s0, in1_s0, ivalid_in2_s0, in2_s0, oready_out1_s0,
    output iready_in1_s0, iready_in2_s0, ovalid_out1_s0, out1_s0, out2_s0, skew_err
  );

endinterface

// File: rtl/kernel_top_stream_join2_fifo_fwft.sv
// Elastic first-word-fall-through FIFO, DEPTH words of W bits.
// Latency: word written at edge k appears on rd_data right after edge k.
// Backpressure: full is from the registered count; writes while full are dropped.
module kernel_top_stream_fifo_fwft #(
  parameter int W     = 34,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_ok;
  logic          rd_ok;

  // Guard the handshakes locally so a misbehaving caller cannot corrupt the count.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left unreset; the count alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count is one bit wider than the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/kernel_top_stream_join2.sv
// Joins two skewed streams into one lockstep output via a FWFT FIFO per input.
// Latency: a word pushed at edge k can leave in cycle k+1 once its partner is present.
// Backpressure: iready_inN = not full (registered); both sides pop together on ovalid & oready.
module kernel_top_stream_join2
  import kernel_top_stream_join2_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  kernel_top_stream_join2_if.slave s
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic               full1, full2, empty1, empty2;
  logic [AW:0]        count1, count2;
  logic [STREAMW-1:0] head1, head2;
  logic               iready1, iready2;
  logic               push1, push2, ovalid, pop;
  logic               skew_q;

  // Readies are held low during reset so nothing is accepted while state is being cleared.
  assign iready1 = !full1 && !rst;
  assign iready2 = !full2 && !rst;
  assign push1   = s.ivalid_in1_s0 && iready1;
  assign push2   = s.ivalid_in2_s0 && iready2;
  assign ovalid  = !empty1 && !empty2;
  assign pop     = ovalid && s.oready_out1_s0;

  assign s.iready_in1_s0  = iready1;
  assign s.iready_in2_s0  = iready2;
  assign s.ovalid_out1_s0 = ovalid;
  assign s.out1_s0        = ovalid ? head1 : '0;
  assign s.out2_s0        = ovalid ? head2 : '0;
  assign s.skew_err       = skew_q;

  kernel_top_stream_fifo_fwft #(.W(STREAMW), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push1),
    .wr_data (s.in1_s0),
    .rd_en   (pop),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1),
    .count   (count1)
  );

  kernel_top_stream_fifo_fwft #(.W(STREAMW), .DEPTH(DEPTH), .AW(AW)) u_fifo2 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push2),
    .wr_data (s.in2_s0),
    .rd_en   (pop),
    .rd_data (head2),
    .full    (full2),
    .empty   (empty2),
    .count   (count2)
  );

  // Sticky flag: one side saturated while the other has nothing means the skew exceeds DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_q <= 1'b0;
    end else if (((count1 == FULL_CNT) && (count2 == '0)) ||
                 ((count2 == FULL_CNT) && (count1 == '0))) begin
      skew_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kernel_top_stream_join2.sv
module tb_kernel_top_stream_join2;
  import kernel_top_stream_join2_pkg::*;

  localparam int DEPTH = DEF_DEPTH;

  logic clk;
  logic rst;

  kernel_top_stream_join2_if #(.STREAMW(DEF_STREAMW)) bus ();

  kernel_top_stream_join2 dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue per input, paired pops, sticky skew flag.
  word_t q1[$];
  word_t q2[$];
  bit    e_skew;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rnd_word();
    return {2'($urandom_range(3, 0)), 32'($urandom)};
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit v1, input word_t d1, input bit v2, input word_t d2,
                      input bit ordy, output bit a1, output bit a2);
    bit    er1, er2, eov, popd;
    word_t eo1, eo2;
    bus.ivalid_in1_s0  = v1;
    bus.in1_s0         = d1;
    bus.ivalid_in2_s0  = v2;
    bus.in2_s0         = d2;
    bus.oready_out1_s0 = ordy;
    @(negedge clk);
    er1 = !rst && (q1.size() < DEPTH);
    er2 = !rst && (q2.size() < DEPTH);
    eov = !rst && (q1.size() > 0) && (q2.size() > 0);
    eo1 = eov ? q1[0] : '0;
    eo2 = eov ? q2[0] : '0;
    chk("iready1", 64'(bus.iready_in1_s0), 64'(er1));
    chk("iready2", 64'(bus.iready_in2_s0), 64'(er2));
    chk("ovalid", 64'(bus.ovalid_out1_s0), 64'(eov));
    chk("out1", 64'(bus.out1_s0), 64'(eo1));
    chk("out2", 64'(bus.out2_s0), 64'(eo2));
    chk("skew_err", 64'(bus.skew_err), 64'(e_skew));
    a1   = v1 && er1;
    a2   = v2 && er2;
    popd = eov && ordy;
    @(posedge clk);
    if (!rst) begin
      if (((q1.size() == DEPTH) && (q2.size() == 0)) ||
          ((q2.size() == DEPTH) && (q1.size() == 0)))
        e_skew = 1'b1;
      if (popd) begin
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (a1) q1.push_back(d1);
      if (a2) q2.push_back(d2);
    end
    #1;
  endtask

  task automatic do_reset();
    bit a1, a2;
    rst = 1'b1;
    q1.delete();
    q2.delete();
    e_skew = 1'b0;
    #1;
    step(1'b1, rnd_word(), 1'b1, rnd_word(), 1'b1, a1, a2);
    rst = 1'b0;
  endtask

  initial begin
    bit    a1, a2, p1, p2;
    word_t d1, d2;
    int    i1, i2;

    rst = 1'b1;
    bus.ivalid_in1_s0  = 1'b0;
    bus.in1_s0         = '0;
    bus.ivalid_in2_s0  = 1'b0;
    bus.in2_s0         = '0;
    bus.oready_out1_s0 = 1'b0;
    q1.delete();
    q2.delete();
    e_skew = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    step(1'b0, '0, 1'b0, '0, 1'b1, a1, a2);

    // Aligned streams 1..8 with free downstream.
    for (int n = 1; n <= 8; n++) step(1'b1, word_t'(n), 1'b1, word_t'(n), 1'b1, a1, a2);
    for (int n = 0; n < 3; n++) step(1'b0, '0, 1'b0, '0, 1'b1, a1, a2);

    // Stream 2 starts three cycles late; upstream holds unaccepted words.
    i1 = 1;
    i2 = 1;
    for (int c = 0; c < 20; c++) begin
      step(i1 <= 8, word_t'(i1), (c >= 3) && (i2 <= 8), word_t'(100 + i2), 1'b1, a1, a2);
      if (a1) i1++;
      if (a2) i2++;
    end

    // Reset in mid-stream, with words stored.
    for (int n = 0; n < 2; n++) step(1'b1, rnd_word(), 1'b0, '0, 1'b0, a1, a2);
    do_reset();
    step(1'b0, '0, 1'b0, '0, 1'b1, a1, a2);

    // Backpressure for 10 cycles, then a full FIFO sees push and pop together, then drain.
    for (int n = 0; n < 10; n++) step(1'b1, word_t'(200 + n), 1'b1, word_t'(300 + n), 1'b0, a1, a2);
    i1 = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1, word_t'(400 + i1), 1'b1, word_t'(500 + i1), 1'b1, a1, a2);
      if (a1) i1++;
    end
    for (int n = 0; n < 6; n++) step(1'b0, '0, 1'b0, '0, 1'b1, a1, a2);

    // Random traffic with held words and random downstream stalls.
    p1 = 1'b0;
    p2 = 1'b0;
    d1 = '0;
    d2 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p1) begin
        p1 = ($urandom_range(3, 0) != 0);
        d1 = rnd_word();
      end
      if (!p2) begin
        p2 = ($urandom_range(3, 0) != 0);
        d2 = rnd_word();
      end
      step(p1, d1, p2, d2, ($urandom_range(2, 0) != 0), a1, a2);
      if (a1) p1 = 1'b0;
      if (a2) p2 = 1'b0;
    end

    // Only stream 1 driven: skew flag must rise and stick until reset.
    do_reset();
    for (int n = 0; n < 5; n++) step(1'b1, rnd_word(), 1'b0, '0, 1'b1, a1, a2);
    for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b0, '0, 1'b1, a1, a2);
    chk("skew_sticky", 64'(bus.skew_err), 64'd1);
    do_reset();
    chk("skew_cleared", 64'(bus.skew_err), 64'd0);
    step(1'b0, '0, 1'b0, '0, 1'b1, a1, a2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
